// File: rtl/serial_shift_unit.sv
// Multi-cycle shift/rotate engine: executes SHIFTL/SHIFTR/ROLL/ROLR one bit
// position per clock at operand width 8/16/32/64, with valid/ready on both
// the issue and result sides.

package serial_shift_pkg;
  typedef enum logic [3:0] {
    AND    = 4'd0,
    OR     = 4'd1,
    XOR    = 4'd2,
    NOT    = 4'd3,
    SHIFTL = 4'd4,
    SHIFTR = 4'd5,
    ROLL   = 4'd6,
    ROLR   = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {
    BITS_8  = 2'd0,
    BITS_16 = 2'd1,
    BITS_32 = 2'd2,
    BITS_64 = 2'd3
  } sizeFlags_t;

  typedef logic [63:0] ulong_t;
endpackage

module serial_shift_unit
  import serial_shift_pkg::*;
#(
  parameter int COUNT_BITS = 6
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       inValid,
  output logic       inReady,
  input  opcode_t    op,
  input  sizeFlags_t size,
  input  logic       useCarry,
  input  logic       carryIn,
  input  ulong_t     a,
  input  ulong_t     b,
  input  logic       flush,
  output logic       outValid,
  input  logic       outReady,
  output ulong_t     result,
  output logic       carry,
  output logic       badOp
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, state_next;
  ulong_t                  v_q;
  logic                    c_q;
  logic                    bad_q;
  logic [COUNT_BITS-1:0]   cnt_q;
  opcode_t                 op_q;
  sizeFlags_t              size_q;
  logic                    uc_q;
  logic [COUNT_BITS-1:0]   n_in;
  logic                    op_ok;

  // Index of the top bit of the operand (W-1); also the mod-W mask for b.
  function automatic logic [5:0] msb_idx(input sizeFlags_t s);
    case (s)
      BITS_8:  msb_idx = 6'd7;
      BITS_16: msb_idx = 6'd15;
      BITS_32: msb_idx = 6'd31;
      default: msb_idx = 6'd63;
    endcase
  endfunction

  function automatic ulong_t width_mask(input sizeFlags_t s);
    case (s)
      BITS_8:  width_mask = 64'h0000_0000_0000_00FF;
      BITS_16: width_mask = 64'h0000_0000_0000_FFFF;
      BITS_32: width_mask = 64'h0000_0000_FFFF_FFFF;
      default: width_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic is_shift(input opcode_t o);
    is_shift = (o == SHIFTL) || (o == SHIFTR) || (o == ROLL) || (o == ROLR);
  endfunction

  // One bit-position step; bits at or above W are kept clear by the mask.
  function automatic ulong_t step_value(input opcode_t o, input sizeFlags_t s,
                                        input ulong_t v, input logic c,
                                        input logic uc);
    logic [5:0] hi;
    ulong_t     m;
    logic       fill;
    hi = msb_idx(s);
    m  = width_mask(s);
    case (o)
      SHIFTL: step_value = (v << 1) & m;
      SHIFTR: step_value = v >> 1;
      ROLL: begin
        fill       = uc ? c : v[hi];
        step_value = ((v << 1) & m) | {63'd0, fill};
      end
      ROLR: begin
        fill       = uc ? c : v[0];
        step_value = (v >> 1) | ({63'd0, fill} << hi);
      end
      default: step_value = v;
    endcase
  endfunction

  // Left-moving ops shift out the top bit, right-moving ops the bottom bit.
  function automatic logic step_carry(input opcode_t o, input sizeFlags_t s,
                                      input ulong_t v);
    if (o == SHIFTL || o == ROLL) step_carry = v[msb_idx(s)];
    else                          step_carry = v[0];
  endfunction

  assign n_in  = COUNT_BITS'(b & ulong_t'(msb_idx(size)));
  assign op_ok = is_shift(op);

  assign inReady  = (state == IDLE);
  assign outValid = (state == DONE);
  assign result   = v_q;
  assign carry    = c_q;
  assign badOp    = bad_q;

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; flush overrides every transition, including accept.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (inValid) state_next = (op_ok && n_in != '0) ? SHIFT : DONE;
        SHIFT:   if (cnt_q == COUNT_BITS'(1)) state_next = DONE;
        DONE:    if (outReady) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Operand capture at accept, one step per SHIFT cycle, hold in DONE.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      v_q    <= '0;
      c_q    <= 1'b0;
      bad_q  <= 1'b0;
      cnt_q  <= '0;
      op_q   <= SHIFTL;
      size_q <= BITS_8;
      uc_q   <= 1'b0;
    end else if (flush) begin
      v_q   <= '0;
      c_q   <= 1'b0;
      bad_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (inValid) begin
          v_q    <= a & width_mask(size);
          c_q    <= op_ok & useCarry & carryIn;
          bad_q  <= ~op_ok;
          cnt_q  <= op_ok ? n_in : '0;
          op_q   <= op;
          size_q <= size;
          uc_q   <= useCarry;
        end
        SHIFT: begin
          v_q   <= step_value(op_q, size_q, v_q, c_q, uc_q);
          c_q   <= step_carry(op_q, size_q, v_q);
          cnt_q <= cnt_q - COUNT_BITS'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit: hand-computed results, carries and
// latencies for each shift/rotate flavour, backpressure, bad op and aborts.
module tb_serial_shift_unit;
  import serial_shift_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic       inValid;
  logic       inReady;
  opcode_t    op;
  sizeFlags_t size;
  logic       useCarry;
  logic       carryIn;
  ulong_t     a;
  ulong_t     b;
  logic       flush;
  logic       outValid;
  logic       outReady;
  ulong_t     result;
  logic       carry;
  logic       badOp;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_shift_unit #(.COUNT_BITS(6)) dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .op(op), .size(size), .useCarry(useCarry), .carryIn(carryIn),
    .a(a), .b(b), .flush(flush), .outValid(outValid), .outReady(outReady),
    .result(result), .carry(carry), .badOp(badOp)
  );

  always #5 clk = ~clk;

  // Present one operation; returns after the accept edge (+1).
  task automatic start_op(input opcode_t o, input sizeFlags_t s, input logic uc,
                          input logic ci, input ulong_t av, input ulong_t bv,
                          output logic rdy_after);
    @(negedge clk);
    op = o; size = s; useCarry = uc; carryIn = ci; a = av; b = bv;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid   = 1'b0;
    rdy_after = inReady;
  endtask

  // Latency counts rising edges from the accept edge inclusive; -1 on timeout.
  task automatic run_op(input opcode_t o, input sizeFlags_t s, input logic uc,
                        input logic ci, input ulong_t av, input ulong_t bv,
                        output int lat, output logic rdy_after);
    start_op(o, s, uc, ci, av, bv, rdy_after);
    lat = 1;
    while (!outValid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!outValid) lat = -1;
  endtask

  task automatic consume();
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (inReady !== 1'b1) $display("FAIL reset_inReady got %b want 1", inReady); else pass_cnt++;
    total_cnt++; if (outValid !== 1'b0) $display("FAIL reset_outValid got %b want 0", outValid); else pass_cnt++;
    total_cnt++; if (result !== 64'd0) $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b0) $display("FAIL reset_carry got %b want 0", carry); else pass_cnt++;
    total_cnt++; if (badOp !== 1'b0) $display("FAIL reset_badOp got %b want 0", badOp); else pass_cnt++;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_shiftl();
    int lat; logic rdy;
    run_op(SHIFTL, BITS_8, 1'b0, 1'b0, 64'hC0, 64'd1, lat, rdy);
    total_cnt++; if (result !== 64'h80) $display("FAIL shiftl_result got %h want 80", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL shiftl_carry got %b want 1", carry); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL shiftl_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (rdy !== 1'b0) $display("FAIL shiftl_inReady_busy got %b want 0", rdy); else pass_cnt++;
    consume();
  endtask

  task automatic test_rolr();
    int lat; logic rdy;
    run_op(ROLR, BITS_8, 1'b1, 1'b0, 64'h1, 64'd1, lat, rdy);
    total_cnt++; if (result !== 64'h00) $display("FAIL rolr_c0_result got %h want 00", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL rolr_c0_carry got %b want 1", carry); else pass_cnt++;
    consume();
    run_op(ROLR, BITS_8, 1'b1, 1'b1, 64'h1, 64'd1, lat, rdy);
    total_cnt++; if (result !== 64'h80) $display("FAIL rolr_c1_result got %h want 80", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL rolr_c1_carry got %b want 1", carry); else pass_cnt++;
    consume();
    run_op(ROLR, BITS_8, 1'b0, 1'b0, 64'h1, 64'd1, lat, rdy);
    total_cnt++; if (result !== 64'h80) $display("FAIL rolr_nc_result got %h want 80", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL rolr_nc_carry got %b want 1", carry); else pass_cnt++;
    consume();
  endtask

  task automatic test_roll64();
    int lat; logic rdy;
    run_op(ROLL, BITS_64, 1'b0, 1'b0, 64'h8000_0000_0000_0001, 64'd63, lat, rdy);
    total_cnt++; if (result !== 64'hC000_0000_0000_0000) $display("FAIL roll64_result got %h want c000000000000000", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b0) $display("FAIL roll64_carry got %b want 0", carry); else pass_cnt++;
    total_cnt++; if (lat !== 64) $display("FAIL roll64_latency got %0d want 64", lat); else pass_cnt++;
    consume();
  endtask

  task automatic test_wrap_zero();
    int lat; logic rdy;
    run_op(SHIFTR, BITS_8, 1'b0, 1'b0, 64'hFF0F, 64'd9, lat, rdy);
    total_cnt++; if (result !== 64'h07) $display("FAIL wrap_result got %h want 07", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL wrap_carry got %b want 1", carry); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL wrap_latency got %0d want 2", lat); else pass_cnt++;
    consume();
    run_op(SHIFTL, BITS_16, 1'b1, 1'b1, 64'h12345, 64'd0, lat, rdy);
    total_cnt++; if (result !== 64'h2345) $display("FAIL zero_result got %h want 2345", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL zero_carry got %b want 1", carry); else pass_cnt++;
    total_cnt++; if (lat !== 1) $display("FAIL zero_latency got %0d want 1", lat); else pass_cnt++;
    consume();
  endtask

  task automatic test_backpressure();
    int lat; logic rdy;
    run_op(SHIFTR, BITS_16, 1'b0, 1'b0, 64'h8001, 64'd1, lat, rdy);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total_cnt++; if (outValid !== 1'b1 || result !== 64'h4000 || carry !== 1'b1 || inReady !== 1'b0)
        $display("FAIL hold_cycle%0d got v=%b r=%h c=%b rdy=%b want v=1 r=4000 c=1 rdy=0",
                 i, outValid, result, carry, inReady);
      else pass_cnt++;
    end
    consume();
    total_cnt++; if (inReady !== 1'b1) $display("FAIL release_inReady got %b want 1", inReady); else pass_cnt++;
    total_cnt++; if (outValid !== 1'b0) $display("FAIL release_outValid got %b want 0", outValid); else pass_cnt++;
  endtask

  task automatic test_badop();
    int lat; logic rdy;
    run_op(AND, BITS_16, 1'b1, 1'b1, 64'hABCD_1234, 64'd5, lat, rdy);
    total_cnt++; if (badOp !== 1'b1) $display("FAIL badop_flag got %b want 1", badOp); else pass_cnt++;
    total_cnt++; if (result !== 64'h1234) $display("FAIL badop_result got %h want 1234", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b0) $display("FAIL badop_carry got %b want 0", carry); else pass_cnt++;
    total_cnt++; if (lat !== 1) $display("FAIL badop_latency got %0d want 1", lat); else pass_cnt++;
    consume();
  endtask

  task automatic test_flush();
    int lat; logic rdy; logic seen;
    start_op(ROLL, BITS_64, 1'b0, 1'b0, 64'h1, 64'd40, rdy);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    total_cnt++; if (inReady !== 1'b1) $display("FAIL flush_inReady got %b want 1", inReady); else pass_cnt++;
    total_cnt++; if (result !== 64'd0) $display("FAIL flush_result got %h want 0", result); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (outValid) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL flush_no_outValid got %b want 0", seen); else pass_cnt++;
    // Flush coincident with inValid in IDLE must not accept.
    @(negedge clk);
    op = SHIFTL; size = BITS_8; a = 64'h3; b = 64'd0; inValid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0; flush = 1'b0;
    total_cnt++; if (inReady !== 1'b1 || outValid !== 1'b0)
      $display("FAIL flush_accept got rdy=%b v=%b want rdy=1 v=0", inReady, outValid);
    else pass_cnt++;
    run_op(ROLL, BITS_8, 1'b0, 1'b0, 64'h81, 64'd1, lat, rdy);
    total_cnt++; if (result !== 64'h03) $display("FAIL after_flush_result got %h want 03", result); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL after_flush_carry got %b want 1", carry); else pass_cnt++;
    consume();
  endtask

  task automatic test_async_reset();
    logic rdy;
    start_op(SHIFTL, BITS_32, 1'b1, 1'b1, 64'h0F0F_0F0F, 64'd20, rdy);
    repeat (3) @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    total_cnt++; if (inReady !== 1'b1 || outValid !== 1'b0)
      $display("FAIL areset_ctrl got rdy=%b v=%b want rdy=1 v=0", inReady, outValid);
    else pass_cnt++;
    total_cnt++; if (result !== 64'd0 || carry !== 1'b0 || badOp !== 1'b0)
      $display("FAIL areset_data got r=%h c=%b bad=%b want 0 0 0", result, carry, badOp);
    else pass_cnt++;
    @(negedge clk);
    resetN = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    total_cnt++; if (outValid !== 1'b0) $display("FAIL areset_no_pulse got %b want 0", outValid); else pass_cnt++;
  endtask

  initial begin
    inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
    op = SHIFTL; size = BITS_8; useCarry = 1'b0; carryIn = 1'b0;
    a = '0; b = '0;
    test_reset();
    test_shiftl();
    test_rolr();
    test_roll64();
    test_wrap_zero();
    test_backpressure();
    test_badop();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
